// File: rtl/regfile_sb_if.sv
// Read, issue and write-back signals between decode/write-back and the register file.
interface regfile_sb_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
);
  logic [ADDR_W-1:0] rs;
  logic [ADDR_W-1:0] rt;
  logic [DATA_W-1:0] o_A;
  logic [DATA_W-1:0] o_B;
  logic              busy_A;
  logic              busy_B;
  logic              issue_en;
  logic [ADDR_W-1:0] issue_rd;
  logic              issue_ok;
  logic              wb_en;
  logic [ADDR_W-1:0] wb_rd;
  logic [DATA_W-1:0] W;

  // Pipeline side: drives addresses, issue requests and write-back.
  modport master (
    output rs, rt, issue_en, issue_rd, wb_en, wb_rd, W,
    input  o_A, o_B, busy_A, busy_B, issue_ok
  );

  // Register file side.
  modport slave (
    input  rs, rt, issue_en, issue_rd, wb_en, wb_rd, W,
    output o_A, o_B, busy_A, busy_B, issue_ok
  );
endinterface

// File: rtl/regfile_sb.sv
// Register file with hardwired-zero r0, optional write-back bypass and a
// per-register pending-write scoreboard for RAW detection and WAW throttling.
module regfile_sb #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned BYPASS = 1,
  parameter int unsigned PEND_W = 2
) (
  input logic         clk,
  input logic         clr,
  regfile_sb_if.slave rf
);
  localparam int unsigned       NREG = 1 << ADDR_W;
  localparam logic [PEND_W-1:0] PMAX = '1;
  localparam logic [PEND_W-1:0] ONE  = PEND_W'(1);
  localparam bit                BYP  = (BYPASS != 0);

  logic [DATA_W-1:0] regs    [NREG];
  logic [PEND_W-1:0] cnt     [NREG];
  logic [PEND_W-1:0] cnt_nxt [NREG];
  logic              wb_hit_a;
  logic              wb_hit_b;

  // Read port A: zero for r0, forwarded write-back data, else storage.
  always_comb begin
    wb_hit_a  = rf.wb_en && (rf.wb_rd == rf.rs);
    rf.o_A    = '0;
    rf.busy_A = 1'b0;
    if (rf.rs != '0) begin
      rf.o_A = (BYP && wb_hit_a) ? rf.W : regs[rf.rs];
      if (BYP) begin
        // A retiring write-back clears one pending write in the same cycle.
        rf.busy_A = (cnt[rf.rs] > ONE) || ((cnt[rf.rs] == ONE) && !wb_hit_a);
      end else begin
        rf.busy_A = (cnt[rf.rs] != '0);
      end
    end
  end

  // Read port B: identical to port A on rt.
  always_comb begin
    wb_hit_b  = rf.wb_en && (rf.wb_rd == rf.rt);
    rf.o_B    = '0;
    rf.busy_B = 1'b0;
    if (rf.rt != '0) begin
      rf.o_B = (BYP && wb_hit_b) ? rf.W : regs[rf.rt];
      if (BYP) begin
        rf.busy_B = (cnt[rf.rt] > ONE) || ((cnt[rf.rt] == ONE) && !wb_hit_b);
      end else begin
        rf.busy_B = (cnt[rf.rt] != '0);
      end
    end
  end

  // Issue accept: refuse only a saturated counter with no same-cycle retire.
  always_comb begin
    rf.issue_ok = rf.issue_en &&
                  ((rf.issue_rd == '0) ||
                   (cnt[rf.issue_rd] != PMAX) ||
                   (rf.wb_en && (rf.wb_rd == rf.issue_rd)));
  end

  // Scoreboard next state: +1 on accepted issue, -1 on retire of a nonzero count.
  always_comb begin
    for (int unsigned r = 0; r < NREG; r++) begin
      cnt_nxt[r] = cnt[r];
      if (r != 0) begin
        case ({rf.issue_ok && (rf.issue_rd == ADDR_W'(r)),
               rf.wb_en && (rf.wb_rd == ADDR_W'(r)) && (cnt[r] != '0)})
          2'b10:   cnt_nxt[r] = cnt[r] + ONE;
          2'b01:   cnt_nxt[r] = cnt[r] - ONE;
          default: cnt_nxt[r] = cnt[r];
        endcase
      end
    end
  end

  // Storage and scoreboard update; clr wipes everything and blocks this edge's writes.
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int unsigned r = 0; r < NREG; r++) begin
        regs[r] <= '0;
        cnt[r]  <= '0;
      end
    end else begin
      if (rf.wb_en && (rf.wb_rd != '0)) begin
        regs[rf.wb_rd] <= rf.W;
      end
      for (int unsigned r = 0; r < NREG; r++) begin
        cnt[r] <= cnt_nxt[r];
      end
    end
  end
endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed vector table, hand sequences
// for bypass behaviour, then randomized traffic against a reference model.
module tb_regfile_sb;
  localparam int unsigned DW   = 32;
  localparam int unsigned AW   = 5;
  localparam int unsigned NR   = 32;
  localparam int          PMAX = 3;
  localparam int          NVEC = 23;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  regfile_sb_if #(.DATA_W(DW), .ADDR_W(AW)) rf1 ();
  regfile_sb_if #(.DATA_W(DW), .ADDR_W(AW)) rf0 ();

  // The non-bypass instance sees exactly the same inputs.
  assign rf0.rs       = rf1.rs;
  assign rf0.rt       = rf1.rt;
  assign rf0.issue_en = rf1.issue_en;
  assign rf0.issue_rd = rf1.issue_rd;
  assign rf0.wb_en    = rf1.wb_en;
  assign rf0.wb_rd    = rf1.wb_rd;
  assign rf0.W        = rf1.W;

  regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .BYPASS(1), .PEND_W(2)) dut1 (
    .clk(clk), .clr(clr), .rf(rf1.slave)
  );
  regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .BYPASS(0), .PEND_W(2)) dut0 (
    .clk(clk), .clr(clr), .rf(rf0.slave)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: register values and number of outstanding writes.
  logic [31:0] mreg [NR];
  int          mcnt [NR];

  typedef struct {
    logic        c;
    logic [4:0]  rs, rt;
    logic        ie;
    logic [4:0]  ird;
    logic        we;
    logic [4:0]  wrd;
    logic [31:0] w;
    logic [31:0] ea, eb;
    logic        ba, bb, ok;
  } vec_t;

  vec_t tbl [NVEC];

  function automatic vec_t mk(input logic c, input logic [4:0] rs, input logic [4:0] rt,
                              input logic ie, input logic [4:0] ird, input logic we,
                              input logic [4:0] wrd, input logic [31:0] w,
                              input logic [31:0] ea, input logic [31:0] eb,
                              input logic ba, input logic bb, input logic ok);
    vec_t v;
    v.c = c; v.rs = rs; v.rt = rt; v.ie = ie; v.ird = ird; v.we = we;
    v.wrd = wrd; v.w = w; v.ea = ea; v.eb = eb; v.ba = ba; v.bb = bb; v.ok = ok;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic c, input logic [4:0] a, input logic [4:0] b,
                       input logic ie, input logic [4:0] ird, input logic we,
                       input logic [4:0] wrd, input logic [31:0] w);
    clr          = c;
    rf1.rs       = a;
    rf1.rt       = b;
    rf1.issue_en = ie;
    rf1.issue_rd = ird;
    rf1.wb_en    = we;
    rf1.wb_rd    = wrd;
    rf1.W        = w;
  endtask

  function automatic logic m_issue_ok();
    return rf1.issue_en &&
           (rf1.issue_rd == 5'd0 || mcnt[rf1.issue_rd] < PMAX ||
            (rf1.wb_en && rf1.wb_rd == rf1.issue_rd));
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a, input bit byp);
    if (a == 5'd0) return 32'd0;
    if (byp && rf1.wb_en && rf1.wb_rd == a) return rf1.W;
    return mreg[a];
  endfunction

  // Outstanding writes left once this cycle's write-back (if forwarded) retires.
  function automatic logic m_busy(input logic [4:0] a, input bit byp);
    int pend;
    if (a == 5'd0) return 1'b0;
    pend = mcnt[a];
    if (byp && rf1.wb_en && rf1.wb_rd == a && pend > 0) pend--;
    return pend > 0;
  endfunction

  // Advance the model by one clock edge using the inputs now applied.
  task automatic model_step();
    logic ok;
    ok = m_issue_ok();
    if (clr) begin
      for (int i = 0; i < NR; i++) begin
        mreg[i] = 32'd0;
        mcnt[i] = 0;
      end
    end else begin
      if (rf1.wb_en && rf1.wb_rd != 5'd0) mreg[rf1.wb_rd] = rf1.W;
      if (rf1.wb_en && mcnt[rf1.wb_rd] > 0) mcnt[rf1.wb_rd]--;
      if (ok && rf1.issue_rd != 5'd0) mcnt[rf1.issue_rd]++;
    end
  endtask

  task automatic model_check(input string tag);
    chk({tag, " d1 o_A"},    rf1.o_A,      m_read(rf1.rs, 1'b1));
    chk({tag, " d1 o_B"},    rf1.o_B,      m_read(rf1.rt, 1'b1));
    chk({tag, " d1 busy_A"}, rf1.busy_A,   m_busy(rf1.rs, 1'b1));
    chk({tag, " d1 busy_B"}, rf1.busy_B,   m_busy(rf1.rt, 1'b1));
    chk({tag, " d1 ok"},     rf1.issue_ok, m_issue_ok());
    chk({tag, " d0 o_A"},    rf0.o_A,      m_read(rf1.rs, 1'b0));
    chk({tag, " d0 o_B"},    rf0.o_B,      m_read(rf1.rt, 1'b0));
    chk({tag, " d0 busy_A"}, rf0.busy_A,   m_busy(rf1.rs, 1'b0));
    chk({tag, " d0 busy_B"}, rf0.busy_B,   m_busy(rf1.rt, 1'b0));
    chk({tag, " d0 ok"},     rf0.issue_ok, m_issue_ok());
  endtask

  function automatic logic [4:0] raddr();
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 7));
  endfunction

  initial begin
    // clr rs rt ie ird we wrd W | o_A o_B busy_A busy_B issue_ok
    tbl[0]  = mk(0, 5, 31, 1, 0, 0, 0, 32'h0,        32'h0,        32'h0,        0, 0, 1);
    tbl[1]  = mk(0, 7, 0,  0, 0, 1, 7, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0,        0, 0, 0);
    tbl[2]  = mk(0, 7, 7,  0, 0, 0, 0, 32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0);
    tbl[3]  = mk(0, 0, 0,  0, 0, 1, 0, 32'hFFFFFFFF, 32'h0,        32'h0,        0, 0, 0);
    tbl[4]  = mk(0, 0, 7,  0, 0, 0, 0, 32'h0,        32'h0,        32'hDEADBEEF, 0, 0, 0);
    tbl[5]  = mk(0, 9, 0,  1, 9, 0, 0, 32'h0,        32'h0,        32'h0,        0, 0, 1);
    tbl[6]  = mk(0, 9, 9,  0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        1, 1, 0);
    tbl[7]  = mk(0, 9, 7,  0, 0, 1, 9, 32'h11111111, 32'h11111111, 32'hDEADBEEF, 0, 0, 0);
    tbl[8]  = mk(0, 9, 9,  0, 0, 0, 0, 32'h0,        32'h11111111, 32'h11111111, 0, 0, 0);
    tbl[9]  = mk(0, 4, 0,  1, 4, 0, 0, 32'h0,        32'h0,        32'h0,        0, 0, 1);
    tbl[10] = mk(0, 4, 0,  1, 4, 0, 0, 32'h0,        32'h0,        32'h0,        1, 0, 1);
    tbl[11] = mk(0, 4, 0,  1, 4, 0, 0, 32'h0,        32'h0,        32'h0,        1, 0, 1);
    tbl[12] = mk(0, 4, 0,  1, 4, 0, 0, 32'h0,        32'h0,        32'h0,        1, 0, 0);
    tbl[13] = mk(0, 4, 0,  1, 4, 1, 4, 32'h44444444, 32'h44444444, 32'h0,        1, 0, 1);
    tbl[14] = mk(0, 4, 4,  1, 4, 0, 0, 32'h0,        32'h44444444, 32'h44444444, 1, 1, 0);
    tbl[15] = mk(0, 6, 0,  0, 0, 1, 6, 32'h66666666, 32'h66666666, 32'h0,        0, 0, 0);
    tbl[16] = mk(0, 6, 6,  0, 0, 0, 0, 32'h0,        32'h66666666, 32'h66666666, 0, 0, 0);
    tbl[17] = mk(0, 5, 0,  0, 0, 1, 5, 32'h00001234, 32'h00001234, 32'h0,        0, 0, 0);
    tbl[18] = mk(0, 5, 0,  1, 5, 0, 0, 32'h0,        32'h00001234, 32'h0,        0, 0, 1);
    tbl[19] = mk(0, 5, 0,  1, 5, 0, 0, 32'h0,        32'h00001234, 32'h0,        1, 0, 1);
    tbl[20] = mk(1, 5, 7,  1, 5, 1, 5, 32'h0000ABCD, 32'h0000ABCD, 32'hDEADBEEF, 1, 0, 1);
    tbl[21] = mk(0, 5, 7,  1, 5, 0, 0, 32'h0,        32'h0,        32'h0,        0, 0, 1);
    tbl[22] = mk(0, 5, 5,  0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        1, 1, 0);

    for (int i = 0; i < NR; i++) begin
      mreg[i] = 32'd0;
      mcnt[i] = 0;
    end

    // Initial reset.
    drive(1, 0, 0, 0, 0, 0, 0, 32'h0);
    repeat (2) begin
      @(negedge clk);
      model_step();
    end

    // Directed vectors.
    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      drive(tbl[i].c, tbl[i].rs, tbl[i].rt, tbl[i].ie, tbl[i].ird,
            tbl[i].we, tbl[i].wrd, tbl[i].w);
      #1;
      chk($sformatf("v%0d o_A", i),    rf1.o_A,      tbl[i].ea);
      chk($sformatf("v%0d o_B", i),    rf1.o_B,      tbl[i].eb);
      chk($sformatf("v%0d busy_A", i), rf1.busy_A,   tbl[i].ba);
      chk($sformatf("v%0d busy_B", i), rf1.busy_B,   tbl[i].bb);
      chk($sformatf("v%0d ok", i),     rf1.issue_ok, tbl[i].ok);
      model_step();
    end

    // Bypass vs. no bypass: same-cycle write-back to the read register.
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 1, 3, 32'h12345678);
    #1; model_step();
    @(negedge clk);
    drive(0, 3, 3, 0, 0, 1, 3, 32'hA5A5A5A5);
    #1;
    chk("byp d1 o_A", rf1.o_A, 32'hA5A5A5A5);
    chk("byp d0 o_A", rf0.o_A, 32'h12345678);
    model_step();
    @(negedge clk);
    drive(0, 3, 3, 0, 0, 0, 0, 32'h0);
    #1;
    chk("after d1 o_A", rf1.o_A, 32'hA5A5A5A5);
    chk("after d0 o_B", rf0.o_B, 32'hA5A5A5A5);
    model_step();
    // r5 has one pending write; retire it while reading r5.
    @(negedge clk);
    drive(0, 5, 0, 0, 0, 1, 5, 32'h00000055);
    #1;
    chk("retire d1 busy_A", rf1.busy_A, 1'b0);
    chk("retire d0 busy_A", rf0.busy_A, 1'b1);
    chk("retire d1 o_A",    rf1.o_A,    32'h00000055);
    chk("retire d0 o_A",    rf0.o_A,    32'h0);
    model_step();
    @(negedge clk);
    drive(0, 5, 5, 0, 0, 0, 0, 32'h0);
    #1;
    chk("retired d1 busy_A", rf1.busy_A, 1'b0);
    chk("retired d0 busy_B", rf0.busy_B, 1'b0);
    model_step();

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      drive(($urandom_range(0, 63) == 0), raddr(), raddr(),
            ($urandom_range(0, 9) < 6), raddr(),
            ($urandom_range(0, 9) < 4), raddr(), 32'($urandom));
      #1;
      model_check($sformatf("r%0d", n));
      model_step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
